// File: rtl/weight_bram_reader.sv
// Read-side sequencer for one per-neuron weight BRAM: sweeps BASE..BASE+DEPTH-1 and
// streams the words through a 2-entry skid buffer on a valid/ready interface.
module weight_bram_reader #(
  parameter int DEPTH = 28,
  parameter int AW    = 5,
  parameter int DW    = 16,
  parameter int BASE  = 0
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          START,
  output logic          BUSY,
  output logic          DONE,
  output logic [AW-1:0] MEM_ADDR,
  output logic          MEM_EN,
  output logic          MEM_WE,
  output logic [DW-1:0] MEM_DI,
  input  logic [DW-1:0] MEM_DO,
  output logic [DW-1:0] W_DATA,
  output logic          W_VALID,
  input  logic          W_READY,
  output logic          W_LAST,
  output logic [AW-1:0] W_INDEX
);

  // state   | meaning
  // S_IDLE  | waiting for START; nothing buffered or in flight
  // S_FETCH | issuing reads, limited by skid-buffer space
  // S_DRAIN | all reads issued; emptying the buffer, DONE on last pop

  localparam int            CW       = AW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
  localparam logic [AW-1:0] BASE_A   = AW'(BASE);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] issued;
  logic [1:0]    count;
  logic          inflight;
  logic [AW-1:0] inflight_idx;
  logic [DW-1:0] buf_data [2];
  logic [AW-1:0] buf_idx  [2];
  logic [1:0]    buf_last;
  logic          rd_ptr;
  logic          wr_ptr;

  logic          pop;
  logic          issue;
  logic          last_pop;
  logic [1:0]    occ_next;

  assign MEM_WE  = 1'b0;
  assign MEM_DI  = '0;
  assign BUSY    = (state != S_IDLE);
  assign W_VALID = (count != 2'd0);
  assign W_DATA  = buf_data[rd_ptr];
  assign W_INDEX = buf_idx[rd_ptr];
  assign W_LAST  = W_VALID && buf_last[rd_ptr];

  // Occupancy after this edge, counting the in-flight word as already buffered,
  // so a new read is only launched when its data is guaranteed a slot.
  always_comb begin
    pop      = 1'b0;
    occ_next = 2'd0;
    issue    = 1'b0;
    last_pop = 1'b0;
    pop      = W_VALID && W_READY;
    occ_next = count + {1'b0, inflight} - {1'b0, pop};
    issue    = ((state == S_IDLE && START) || state == S_FETCH)
               && (issued < DEPTH_C) && (occ_next < 2'd2);
    last_pop = (state == S_DRAIN) && pop && (count == 2'd1) && !inflight;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state        <= S_IDLE;
      issued       <= '0;
      count        <= 2'd0;
      inflight     <= 1'b0;
      inflight_idx <= '0;
      rd_ptr       <= 1'b0;
      wr_ptr       <= 1'b0;
      buf_last     <= 2'b00;
      DONE         <= 1'b0;
      MEM_EN       <= 1'b0;
      MEM_ADDR     <= BASE_A;
      for (int i = 0; i < 2; i++) begin
        buf_data[i] <= '0;
        buf_idx[i]  <= '0;
      end
    end else begin
      assert (occ_next <= 2'd2);

      DONE     <= last_pop;
      MEM_EN   <= issue;
      inflight <= issue;
      count    <= occ_next;

      if (issue) begin
        MEM_ADDR     <= BASE_A + issued[AW-1:0];
        inflight_idx <= issued[AW-1:0];
        issued       <= issued + CW'(1);
      end

      // BRAM data registered on the negedge of the issue cycle lands here.
      if (inflight) begin
        buf_data[wr_ptr] <= MEM_DO;
        buf_idx[wr_ptr]  <= inflight_idx;
        buf_last[wr_ptr] <= (inflight_idx == LAST_IDX);
        wr_ptr           <= ~wr_ptr;
      end

      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end

      case (state)
        S_IDLE: begin
          if (issue) begin
            state <= (issued + CW'(1) == DEPTH_C) ? S_DRAIN : S_FETCH;
          end
        end
        S_FETCH: begin
          if (issue && (issued + CW'(1) == DEPTH_C)) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (last_pop) begin
            state  <= S_IDLE;
            issued <= '0;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
